ysyx_22041412_irq_taker: RTL and testbench
==========================================

Name: ysyx_22041412_irq_taker

Overview:
Core-side receiver of the CLINT timer interrupt. It samples the level `mtip` line from `ysyx_22041412_clint` and gates it with `mstatus.MIE` and `mie.MTIE`. A pending interrupt is taken only at an instruction-commit boundary. Taking it means writing `mepc`/`mcause`, requesting a pipeline flush and redirect to `mtvec`; the block also executes the `mret` return redirect. It sits between the CLINT, the CSR file and the commit/flush logic of the pipeline.

Parameters:
- XLEN, 64, datapath width of PCs and CSRs.
- MTI_CODE, 7, exception code placed in `mcause` for the machine timer interrupt.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- irq_mtip  in  1  level interrupt from CLINT.
- csr_mstatus_mie  in  1  global machine interrupt enable.
- csr_mie_mtie  in  1  timer interrupt enable.
- csr_mtvec  in  XLEN  trap vector; bits[1:0] are MODE (0 direct, 1 vectored).
- csr_mepc  in  XLEN  current `mepc`, used by `mret`.
- commit_valid  in  1  an instruction retires this cycle.
- commit_next_pc  in  XLEN  PC of the instruction following the retiring one.
- commit_mret  in  1  the retiring instruction is `mret`; qualified by `commit_valid`.
- pipe_ack  in  1  pipeline reports that the flush and redirect are complete.
- trap_req  out  1  flush pipeline and fetch from `trap_pc`; held until `pipe_ack`.
- trap_pc  out  XLEN  redirect target.
- csr_trap_we  out  1  one-cycle pulse: write `mepc`/`mcause`, set `MPIE`=`MIE`, set `MIE`=0.
- csr_mepc_wdata  out  XLEN  value to write into `mepc`.
- csr_mcause_wdata  out  XLEN  value to write into `mcause`.
- csr_mret_we  out  1  one-cycle pulse: set `MIE`=`MPIE`, set `MPIE`=1.
- irq_taken_cnt  out  16  count of interrupts taken; wraps.

Behaviour:
- Reset (`rst`=0, async): state=IDLE. All outputs are 0: `trap_req`, `trap_pc`, both `_we` pulses, both `_wdata` buses and `irq_taken_cnt`. The `mtip` sample register is also 0.
- `mtip_q` registers `irq_mtip` every cycle. This gives one cycle of input latency.
- pending = `mtip_q` & `csr_mstatus_mie` & `csr_mie_mtie`. It is evaluated combinationally each cycle.
- States: IDLE, TRAP, MRET.
- IDLE -> MRET when `commit_valid` & `commit_mret`. Next cycle:
  - `csr_mret_we`=1 for one cycle;
  - `trap_req`=1;
  - `trap_pc`=`csr_mepc` sampled at the commit edge.
- IDLE -> TRAP when `commit_valid` & !`commit_mret` & pending. Next cycle:
  - `csr_trap_we`=1 for one cycle;
  - `csr_mepc_wdata`=`commit_next_pc`;
  - `csr_mcause_wdata`={1'b1, (XLEN-1)'(MTI_CODE)};
  - `trap_req`=1;
  - `irq_taken_cnt`+=1.
- Target PC in TRAP: base = `csr_mtvec` & ~3. MODE 0 gives `trap_pc`=base. MODE 1 gives `trap_pc`=base + 4*MTI_CODE. MODE 2 and 3 are treated as 0.
- TRAP/MRET -> IDLE on the cycle `pipe_ack`=1. In that cycle `trap_req` drops to 0 and `trap_pc` holds its value.
- `pipe_ack` may arrive in the first cycle of TRAP/MRET; that is a minimum 1-cycle `trap_req`.
- `mret` has priority over the interrupt when both occur on the same commit. After `MIE` is restored, a still-pending interrupt is taken at the next commit.
- Pending without `commit_valid`: wait in IDLE with no action.
- `irq_mtip` falling before a commit boundary: no trap.
- Inputs ignored outside IDLE: `commit_valid` and `commit_mret` are ignored in TRAP/MRET, because the pipeline is flushing. `pipe_ack` is ignored in IDLE.
- Pending is not re-armed during TRAP. The CSR write clears `MIE`, so no nested take occurs.
- `irq_taken_cnt` wraps from 0xFFFF to 0x0000.
- Reset asserted mid-TRAP/MRET: immediate return to IDLE with all outputs 0. No partial CSR write is reissued.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, TRAP=2'd1, MRET=2'd2);
  - the `mcause` interrupt bit position;
  - MTI_CODE;
  - the `mtvec` MODE constants.
- One natural sub-module: ysyx_22041412_trap_vec, the combinational computation of `trap_pc` from `mtvec` and cause. The FSM stays in the top level.

Test Plan:
- Direct take: `mtvec`=0x8000_0100 (MODE 0), MIE=MTIE=1. Raise `mtip`, then `commit_valid` with `next_pc`=0x8000_0040 two cycles later. Required next cycle: `csr_trap_we`=1, `mepc_wdata`=0x8000_0040, `mcause`=0x8000_0000_0000_0007, `trap_pc`=0x8000_0100, `irq_taken_cnt`=1.
- Vectored: `mtvec`=0x8000_0101. Required `trap_pc`=0x8000_011C. With `pipe_ack` 3 cycles later, `trap_req` is high for exactly 3 cycles.
- Masking: `mtip`=1 and MTIE=0 with 10 commits gives no `csr_trap_we`. Setting MTIE=1 gives a take on the next commit.
- `mret`+pending on the same commit with `mepc`=0x8000_2000: required `csr_mret_we`=1 and `trap_pc`=0x8000_2000. `csr_trap_we` stays 0 that cycle.
- Glitch and wrap: `mtip` pulses high for 1 cycle with no commit, so no take. Preload 0xFFFF takes, then one more take, gives `irq_taken_cnt`=0.
- Reset mid-TRAP: drop `rst` while `trap_req`=1. Required: all outputs 0 asynchronously, and state IDLE after release.

Source files
------------

// File: rtl/ysyx_22041412_irq_taker_pkg.sv
// Shared definitions for the machine-timer interrupt taker: FSM encoding,
// mcause layout and mtvec mode values.
package ysyx_22041412_irq_taker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TRAP = 2'd1,
      ST_MRET = 2'd2
   } state_e;

   localparam int MTI_CODE = 7;

   localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

   // The interrupt flag always sits in the top bit of mcause.
   function automatic int mcause_int_bit(input int xlen);
      return xlen - 1;
   endfunction

endpackage

// File: rtl/ysyx_22041412_trap_vec.sv
// Trap target computation from mtvec: direct mode jumps to the base,
// vectored mode offsets the base by 4*cause. Reserved modes act as direct.
module ysyx_22041412_trap_vec
   import ysyx_22041412_irq_taker_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] cause_code,
   output logic [XLEN-1:0] vec_pc
);

   logic [XLEN-1:0] base;

   always_comb begin
      base   = {mtvec[XLEN-1:2], 2'b00};
      vec_pc = base;
      if (mtvec[1:0] == MTVEC_MODE_VECTORED) begin
         vec_pc = base + (cause_code << 2);
      end
   end

endmodule

// File: rtl/ysyx_22041412_irq_taker.sv
// Takes the CLINT timer interrupt at commit boundaries and executes mret
// redirects; drives the CSR trap/return writes and the pipeline flush request.
module ysyx_22041412_irq_taker
   import ysyx_22041412_irq_taker_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter int MTI_CODE = ysyx_22041412_irq_taker_pkg::MTI_CODE
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            irq_mtip,
   input  logic            csr_mstatus_mie,
   input  logic            csr_mie_mtie,
   input  logic [XLEN-1:0] csr_mtvec,
   input  logic [XLEN-1:0] csr_mepc,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_next_pc,
   input  logic            commit_mret,
   input  logic            pipe_ack,
   output logic            trap_req,
   output logic [XLEN-1:0] trap_pc,
   output logic            csr_trap_we,
   output logic [XLEN-1:0] csr_mepc_wdata,
   output logic [XLEN-1:0] csr_mcause_wdata,
   output logic            csr_mret_we,
   output logic [15:0]     irq_taken_cnt
);

   localparam logic [XLEN-1:0] MTI_CAUSE  = XLEN'(MTI_CODE);
   localparam logic [XLEN-1:0] MCAUSE_MTI = (XLEN'(1) << mcause_int_bit(XLEN)) | MTI_CAUSE;

   state_e          state_q, state_d;
   logic            mtip_q;
   logic            trap_req_q, trap_req_d;
   logic [XLEN-1:0] trap_pc_q, trap_pc_d;
   logic            trap_we_q, trap_we_d;
   logic            mret_we_q, mret_we_d;
   logic [XLEN-1:0] mepc_wdata_q, mepc_wdata_d;
   logic [XLEN-1:0] mcause_wdata_q, mcause_wdata_d;
   logic [15:0]     irq_taken_cnt_q, irq_taken_cnt_d;

   logic            pending;
   logic [XLEN-1:0] vec_pc;

   ysyx_22041412_trap_vec #(.XLEN(XLEN)) u_trap_vec (
      .mtvec      (csr_mtvec),
      .cause_code (MTI_CAUSE),
      .vec_pc     (vec_pc)
   );

   assign pending = mtip_q & csr_mstatus_mie & csr_mie_mtie;

   always_comb begin
      state_d         = state_q;
      trap_req_d      = trap_req_q;
      trap_pc_d       = trap_pc_q;
      trap_we_d       = 1'b0;
      mret_we_d       = 1'b0;
      mepc_wdata_d    = mepc_wdata_q;
      mcause_wdata_d  = mcause_wdata_q;
      irq_taken_cnt_d = irq_taken_cnt_q;
      case (state_q)
         ST_IDLE: begin
            // mret wins over a simultaneous interrupt; the interrupt is
            // retried on a later commit once MIE has been restored.
            if (commit_valid && commit_mret) begin
               state_d    = ST_MRET;
               trap_req_d = 1'b1;
               trap_pc_d  = csr_mepc;
               mret_we_d  = 1'b1;
            end else if (commit_valid && pending) begin
               state_d         = ST_TRAP;
               trap_req_d      = 1'b1;
               trap_pc_d       = vec_pc;
               trap_we_d       = 1'b1;
               mepc_wdata_d    = commit_next_pc;
               mcause_wdata_d  = MCAUSE_MTI;
               irq_taken_cnt_d = irq_taken_cnt_q + 16'd1;
            end
         end
         ST_TRAP, ST_MRET: begin
            if (pipe_ack) begin
               state_d    = ST_IDLE;
               trap_req_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_IDLE;
         mtip_q          <= 1'b0;
         trap_req_q      <= 1'b0;
         trap_pc_q       <= '0;
         trap_we_q       <= 1'b0;
         mret_we_q       <= 1'b0;
         mepc_wdata_q    <= '0;
         mcause_wdata_q  <= '0;
         irq_taken_cnt_q <= '0;
      end else begin
         state_q         <= state_d;
         mtip_q          <= irq_mtip;
         trap_req_q      <= trap_req_d;
         trap_pc_q       <= trap_pc_d;
         trap_we_q       <= trap_we_d;
         mret_we_q       <= mret_we_d;
         mepc_wdata_q    <= mepc_wdata_d;
         mcause_wdata_q  <= mcause_wdata_d;
         irq_taken_cnt_q <= irq_taken_cnt_d;
      end
   end

   assign trap_req         = trap_req_q;
   assign trap_pc          = trap_pc_q;
   assign csr_trap_we      = trap_we_q;
   assign csr_mret_we      = mret_we_q;
   assign csr_mepc_wdata   = mepc_wdata_q;
   assign csr_mcause_wdata = mcause_wdata_q;
   assign irq_taken_cnt    = irq_taken_cnt_q;

endmodule

// File: tb/tb_ysyx_22041412_irq_taker.sv
// Scoreboard bench for the timer interrupt taker: stimulus pushes expected
// CSR pulses and trap_req lengths; a monitor pops and compares them.
module tb_ysyx_22041412_irq_taker;

   localparam logic [63:0] MCAUSE_EXP = 64'h8000_0000_0000_0007;

   typedef struct {
      bit          is_mret;
      logic [63:0] pc;
      logic [63:0] mepc;
      logic [15:0] cnt;
   } evt_t;

   typedef struct {
      bit          full;
      bit          q_empty;
      logic        trap_req;
      logic [63:0] trap_pc;
      logic        trap_we;
      logic        mret_we;
      logic [63:0] mepc_wd;
      logic [63:0] mcause_wd;
      logic [15:0] cnt;
   } snap_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        irq_mtip = 1'b0;
   logic        csr_mstatus_mie = 1'b0;
   logic        csr_mie_mtie = 1'b0;
   logic [63:0] csr_mtvec = '0;
   logic [63:0] csr_mepc = '0;
   logic        commit_valid = 1'b0;
   logic [63:0] commit_next_pc = '0;
   logic        commit_mret = 1'b0;
   logic        pipe_ack = 1'b0;
   logic        trap_req;
   logic [63:0] trap_pc;
   logic        csr_trap_we;
   logic [63:0] csr_mepc_wdata;
   logic [63:0] csr_mcause_wdata;
   logic        csr_mret_we;
   logic [15:0] irq_taken_cnt;

   evt_t  exp_q[$];
   int    len_q[$];
   snap_t snap_exp;
   int    snap_seq = 0;
   int    snap_done = 0;
   int    run_len = 0;
   int    n_checks = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   ysyx_22041412_irq_taker #(.XLEN(64), .MTI_CODE(7)) dut (
      .clk              (clk),
      .rst              (rst),
      .irq_mtip         (irq_mtip),
      .csr_mstatus_mie  (csr_mstatus_mie),
      .csr_mie_mtie     (csr_mie_mtie),
      .csr_mtvec        (csr_mtvec),
      .csr_mepc         (csr_mepc),
      .commit_valid     (commit_valid),
      .commit_next_pc   (commit_next_pc),
      .commit_mret      (commit_mret),
      .pipe_ack         (pipe_ack),
      .trap_req         (trap_req),
      .trap_pc          (trap_pc),
      .csr_trap_we      (csr_trap_we),
      .csr_mepc_wdata   (csr_mepc_wdata),
      .csr_mcause_wdata (csr_mcause_wdata),
      .csr_mret_we      (csr_mret_we),
      .irq_taken_cnt    (irq_taken_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: also wakes on reset assertion so asynchronous clearing is visible
   // before any clock edge.
   always @(negedge clk or negedge rst) begin
      #1;
      if (!rst) begin
         run_len = 0;
      end else if (trap_req) begin
         run_len++;
      end else if (run_len > 0) begin
         if (len_q.size() == 0) chk("unexpected trap_req run", 64'(run_len), 64'd0);
         else chk("trap_req length", 64'(run_len), 64'(len_q.pop_front()));
         run_len = 0;
      end
      if (csr_trap_we || csr_mret_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected csr pulse", {62'd0, csr_trap_we, csr_mret_we}, 64'd0);
         end else begin
            evt_t e;
            e = exp_q.pop_front();
            chk("trap_we", 64'(csr_trap_we), 64'(!e.is_mret));
            chk("mret_we", 64'(csr_mret_we), 64'(e.is_mret));
            chk("trap_req at pulse", 64'(trap_req), 64'd1);
            chk("trap_pc", trap_pc, e.pc);
            chk("irq_taken_cnt", 64'(irq_taken_cnt), 64'(e.cnt));
            if (!e.is_mret) begin
               chk("mepc_wdata", csr_mepc_wdata, e.mepc);
               chk("mcause_wdata", csr_mcause_wdata, MCAUSE_EXP);
            end
         end
      end
      if (snap_seq != snap_done) begin
         snap_done = snap_seq;
         chk("snap trap_req", 64'(trap_req), 64'(snap_exp.trap_req));
         chk("snap trap_we", 64'(csr_trap_we), 64'(snap_exp.trap_we));
         chk("snap mret_we", 64'(csr_mret_we), 64'(snap_exp.mret_we));
         chk("snap cnt", 64'(irq_taken_cnt), 64'(snap_exp.cnt));
         if (snap_exp.full) begin
            chk("snap trap_pc", trap_pc, snap_exp.trap_pc);
            chk("snap mepc_wdata", csr_mepc_wdata, snap_exp.mepc_wd);
            chk("snap mcause_wdata", csr_mcause_wdata, snap_exp.mcause_wd);
         end
         if (snap_exp.q_empty) begin
            chk("pending pulse expectations", 64'(exp_q.size()), 64'd0);
            chk("pending length expectations", 64'(len_q.size()), 64'd0);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap_zero(input bit q_empty);
      snap_exp = '{full: 1'b1, q_empty: q_empty, trap_req: 1'b0, trap_pc: '0, trap_we: 1'b0,
                   mret_we: 1'b0, mepc_wd: '0, mcause_wd: '0, cnt: '0};
   endtask

   task automatic snap_idle(input logic [15:0] cnt, input bit q_empty);
      snap_exp = '{full: 1'b0, q_empty: q_empty, trap_req: 1'b0, trap_pc: '0, trap_we: 1'b0,
                   mret_we: 1'b0, mepc_wd: '0, mcause_wd: '0, cnt: cnt};
      snap_seq++;
      step();
   endtask

   // One commit; ack > 0 acks after that many trap_req cycles, 0 leaves it pending.
   task automatic commit(input bit mret, input logic [63:0] npc, input logic [63:0] pc,
                         input logic [15:0] cnt, input int ack);
      commit_valid   = 1'b1;
      commit_mret    = mret;
      commit_next_pc = npc;
      exp_q.push_back('{is_mret: mret, pc: pc, mepc: npc, cnt: cnt});
      step();
      commit_valid = 1'b0;
      commit_mret  = 1'b0;
      if (ack > 0) begin
         len_q.push_back(ack);
         if (ack > 1) step(ack - 1);
         pipe_ack = 1'b1;
         step();
         pipe_ack = 1'b0;
         step();
      end
   endtask

   initial begin
      step(2);
      snap_zero(1'b0);
      snap_seq++;
      step();
      rst = 1'b1;
      step();

      // direct mode take
      csr_mtvec = 64'h8000_0100;
      csr_mstatus_mie = 1'b1;
      csr_mie_mtie = 1'b1;
      irq_mtip = 1'b1;
      step(2);
      commit(1'b0, 64'h8000_0040, 64'h8000_0100, 16'd1, 1);

      // vectored mode, 3-cycle flush
      csr_mtvec = 64'h8000_0101;
      commit(1'b0, 64'h8000_0080, 64'h8000_011C, 16'd2, 3);

      // masked by MTIE across 10 commits, then enabled
      csr_mie_mtie = 1'b0;
      for (int i = 0; i < 10; i++) begin
         commit_valid   = 1'b1;
         commit_next_pc = 64'h8000_1000 + 64'(4 * i);
         step();
         commit_valid = 1'b0;
         step();
      end
      snap_idle(16'd2, 1'b1);
      csr_mie_mtie = 1'b1;
      commit(1'b0, 64'h8000_00C0, 64'h8000_011C, 16'd3, 1);

      // mret and pending on the same commit: mret wins, interrupt follows
      csr_mepc = 64'h8000_2000;
      commit(1'b1, 64'h8000_0104, 64'h8000_2000, 16'd3, 2);
      commit(1'b0, 64'h8000_2000, 64'h8000_011C, 16'd4, 1);

      // single-cycle mtip glitch with no commit
      irq_mtip = 1'b0;
      step(3);
      irq_mtip = 1'b1;
      step();
      irq_mtip = 1'b0;
      step(3);
      for (int i = 0; i < 3; i++) begin
         commit_valid   = 1'b1;
         commit_next_pc = 64'h8000_3000;
         step();
         commit_valid = 1'b0;
         step();
      end
      snap_idle(16'd4, 1'b1);

      // counter wrap from 0xFFFF
      @(negedge clk);
      force dut.irq_taken_cnt_q = 16'hFFFF;
      #2;
      release dut.irq_taken_cnt_q;
      step();
      snap_idle(16'hFFFF, 1'b1);
      irq_mtip = 1'b1;
      step(2);
      commit(1'b0, 64'h8000_0300, 64'h8000_011C, 16'h0000, 1);

      // reset while trap_req is held
      commit(1'b0, 64'h8000_0400, 64'h8000_011C, 16'h0001, 0);
      @(negedge clk);
      #3;
      snap_zero(1'b0);
      snap_seq++;
      rst = 1'b0;
      step(2);
      rst = 1'b1;
      step();
      snap_idle(16'd0, 1'b1);
      commit(1'b0, 64'h8000_0500, 64'h8000_011C, 16'd1, 1);

      snap_idle(16'd1, 1'b1);
      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
